// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for keypad consumers.
//   - ASCII constants for the line framing (CR, LF, '0', 'A')
//   - byte_sel encodings for the transmit sequencer
//   - hex_to_ascii : 4-bit hex digit -> uppercase ASCII character
//   - onehot_idx   : 4-bit one-hot -> {valid, 2-bit bit position}
//   - tx_state_t   : transmit sequencer states
package keypad_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  // Which byte of the current line is held in tx_data.
  localparam logic [1:0] SEL_DIGIT = 2'd0;
  localparam logic [1:0] SEL_CR    = 2'd1;
  localparam logic [1:0] SEL_LF    = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT
  } tx_state_t;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_ZERO + {4'h0, n};
    else           return ASCII_A + {4'h0, n - 4'd10};
  endfunction

  // Returns {valid, index}; valid is clear unless exactly one bit is set.
  function automatic logic [2:0] onehot_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 3'b100;
      4'b0010: return 3'b101;
      4'b0100: return 3'b110;
      4'b1000: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: synchronous first-word-fall-through FIFO for keypad entries.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (flushes contents)
//   push, din    : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   dout         : head entry, valid whenever empty is low
//   full, empty  : registered flags reflecting occupancy after this cycle
// Fullness is judged before a same-cycle pop, so a push into a full
// FIFO is discarded even when a pop happens in the same cycle.
module key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push    = push && !full;
    do_pop     = pop && !empty;
    count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW + 1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/key_tx_framer.sv
// key_tx_framer: keypad event -> UART line framer.
// Decodes one-hot {col,row} key codes to hex digits, discards auto-repeats
// inside a holdoff window, buffers digits in key_fifo and sends each as
// ASCII digit (+ CR LF when EOL_EN) over the transmitter ready/trigger
// handshake.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   key_valid   : one-cycle pulse qualifying key_code
//   key_code    : [7:4] column one-hot, [3:0] row one-hot
//   tx_ready    : transmitter can accept a byte
//   tx_trigger  : one-cycle pulse, tx_data valid
//   tx_data     : byte to transmit, stable between triggers
//   fifo_full   : key buffer holds FIFO_DEPTH entries
//   drop_count  : saturating count of malformed and overflow drops
//   last_key    : hex index of the most recently accepted key
module key_tx_framer
  import keypad_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned REPEAT_HOLDOFF = 12_000_000,
  parameter int unsigned EOL_EN         = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       tx_ready,
  output logic       tx_trigger,
  output logic [7:0] tx_data,
  output logic       fifo_full,
  output logic [7:0] drop_count,
  output logic [3:0] last_key
);

  localparam int unsigned HOLD_W = (REPEAT_HOLDOFF == 0) ? 1 : $clog2(REPEAT_HOLDOFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_HOLDOFF);
  localparam bit EOL_ON = (EOL_EN != 0);

  // Decode and repeat filter
  logic [2:0]        col_dec;
  logic [2:0]        row_dec;
  logic              well_formed;
  logic [3:0]        key_idx;
  logic              is_repeat;
  logic              accept;
  logic              drop_event;
  logic [7:0]        last_code;
  logic [HOLD_W-1:0] holdoff_cnt;

  // FIFO and sequencer
  logic      fifo_pop;
  logic      fifo_empty;
  logic [3:0] fifo_dout;
  tx_state_t state;
  tx_state_t state_next;
  logic [1:0] byte_sel;
  logic      send_cr;
  logic      send_lf;
  logic      load_cr;
  logic      load_lf;

  always_comb begin
    col_dec     = onehot_idx(key_code[7:4]);
    row_dec     = onehot_idx(key_code[3:0]);
    well_formed = col_dec[2] && row_dec[2];
    key_idx     = {row_dec[1:0], col_dec[1:0]};
    // last_code resets to 0, which is never well formed, so no false match.
    is_repeat   = (key_code == last_code) && (holdoff_cnt != '0);
    accept      = key_valid && well_formed && !is_repeat;
    // Overflow uses the registered flag: fullness is judged before any pop.
    drop_event  = (key_valid && !well_formed) || (accept && fifo_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_code   <= '0;
      last_key    <= '0;
      holdoff_cnt <= '0;
      drop_count  <= '0;
    end else begin
      if (accept) begin
        last_code   <= key_code;
        last_key    <= key_idx;
        holdoff_cnt <= HOLD_RELOAD;
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
      if (drop_event && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  key_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(4)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (accept),
    .din  (key_idx),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    send_cr = (byte_sel == SEL_DIGIT) && EOL_ON;
    send_lf = (byte_sel == SEL_CR);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   if (tx_ready) state_next = HOLD;
      HOLD:    state_next = WAIT;
      WAIT:    if (tx_ready) state_next = (send_cr || send_lf) ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_trigger = 1'b0;
    fifo_pop   = 1'b0;
    load_cr    = 1'b0;
    load_lf    = 1'b0;
    case (state)
      IDLE:  fifo_pop   = !fifo_empty;
      ISSUE: tx_trigger = tx_ready;
      WAIT: begin
        load_cr = tx_ready && send_cr;
        load_lf = tx_ready && send_lf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data  <= '0;
      byte_sel <= SEL_DIGIT;
    end else if (fifo_pop) begin
      tx_data  <= hex_to_ascii(fifo_dout);
      byte_sel <= SEL_DIGIT;
    end else if (load_cr) begin
      tx_data  <= ASCII_CR;
      byte_sel <= SEL_CR;
    end else if (load_lf) begin
      tx_data  <= ASCII_LF;
      byte_sel <= SEL_LF;
    end
  end

endmodule

// File: tb/tb_key_tx_framer.sv
// Testbench for key_tx_framer: table-driven key vectors, directed corner
// sequences (saturation, overflow, holdoff window, reset mid-frame) and a
// randomized run scored against a key-level reference model.
module tb_key_tx_framer;

  localparam int HOLD = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       tx_ready;

  logic       trig_a, trig_b;
  logic [7:0] data_a, data_b;
  logic       full_a, full_b;
  logic [7:0] drops_a, drops_b;
  logic [3:0] last_a, last_b;

  always #5 clk = ~clk;

  key_tx_framer #(.FIFO_DEPTH(4), .REPEAT_HOLDOFF(HOLD), .EOL_EN(1)) dut_a (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .tx_ready(tx_ready), .tx_trigger(trig_a), .tx_data(data_a),
    .fifo_full(full_a), .drop_count(drops_a), .last_key(last_a)
  );

  key_tx_framer #(.FIFO_DEPTH(4), .REPEAT_HOLDOFF(0), .EOL_EN(0)) dut_b (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .tx_ready(tx_ready), .tx_trigger(trig_b), .tx_data(data_b),
    .fifo_full(full_b), .drop_count(drops_b), .last_key(last_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Trigger monitor and scoreboard
  logic [7:0] cap_a[$];
  int         cap_a_cyc[$];
  logic [7:0] cap_b[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int         last_trig  = -100;
  bit         rand_mode  = 1'b0;
  int         pending    = 0;
  int         rand_bytes = 0;

  always @(negedge clk) begin
    if (trig_a) begin
      check("trig_when_ready", tx_ready, 1);
      check("trig_spacing_ge3", (cyc - last_trig) >= 3, 1);
      last_trig = cyc;
      cap_a.push_back(data_a);
      cap_a_cyc.push_back(cyc);
      if (rand_mode) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_byte", exp_q.size(), 1);
        end else begin
          exp_byte = exp_q.pop_front();
          check("rand_byte", data_a, exp_byte);
          rand_bytes++;
          if (rand_bytes % 3 == 0) pending--;
        end
      end
    end
    if (trig_b) cap_b.push_back(data_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_a.delete();
    cap_a_cyc.delete();
    cap_b.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 8'h00;
    tx_ready  = 1'b0;
    repeat (3) tick();
    reset     = 1'b0;
    last_trig = -100;
    clear_caps();
  endtask

  task automatic send_key(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic send_at(input logic [7:0] code, input int c);
    while (cyc < c) tick();
    send_key(code);
  endtask

  task automatic wait_caps(input int n, input int budget);
    int b;
    b = budget;
    while (cap_a.size() < n && b > 0) begin
      tick();
      b--;
    end
  endtask

  // Reference helpers (specification arithmetic, not RTL structure)
  function automatic int bitpos(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] ascii_of(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [3:0] idx;
    logic [7:0] ascii;
  } vec_t;

  vec_t tbl [10];

  logic [7:0] exp_lines[$];
  logic [7:0] rcode;
  int kc, t0, a0, exp_drop, exp_last;
  int m_drop, m_last, m_acc, waited, gap, r, c, budget;
  logic [7:0] m_code;
  bit have_acc;

  initial begin
    tbl = '{
      '{8'h11, 1'b0, 4'd0,  8'h30},
      '{8'h88, 1'b0, 4'd15, 8'h46},
      '{8'h84, 1'b0, 4'd11, 8'h42},
      '{8'h31, 1'b1, 4'd0,  8'h00},
      '{8'h12, 1'b0, 4'd4,  8'h34},
      '{8'h10, 1'b1, 4'd0,  8'h00},
      '{8'h21, 1'b0, 4'd1,  8'h31},
      '{8'h48, 1'b0, 4'd14, 8'h45},
      '{8'h24, 1'b0, 4'd9,  8'h39},
      '{8'h81, 1'b0, 4'd3,  8'h33}
    };

    // Reset values
    do_reset();
    check("rst_trigger", trig_a, 0);
    check("rst_tx_data", data_a, 8'h00);
    check("rst_fifo_full", full_a, 0);
    check("rst_drop_count", drops_a, 0);
    check("rst_last_key", last_a, 0);

    // Table of single keys with the transmitter always ready
    tx_ready = 1'b1;
    exp_drop = 0;
    exp_last = 0;
    for (int i = 0; i < 10; i++) begin
      clear_caps();
      kc = cyc;
      send_key(tbl[i].code);
      repeat (20) tick();
      if (tbl[i].bad) begin
        exp_drop++;
        check("tbl_bad_no_tx", cap_a.size(), 0);
        check("tbl_bad_no_tx_b", cap_b.size(), 0);
      end else begin
        exp_last = tbl[i].idx;
        check("tbl_trig_count", cap_a.size(), 3);
        if (cap_a.size() == 3) begin
          check("tbl_digit", cap_a[0], tbl[i].ascii);
          check("tbl_cr", cap_a[1], 8'h0D);
          check("tbl_lf", cap_a[2], 8'h0A);
          check("tbl_first_latency", cap_a_cyc[0] - kc, 2);
        end
        check("tbl_noeol_count", cap_b.size(), 1);
        if (cap_b.size() == 1) check("tbl_noeol_digit", cap_b[0], tbl[i].ascii);
      end
      check("tbl_last_key", last_a, exp_last);
      check("tbl_drop_count", drops_a, exp_drop);
      check("tbl_last_key_b", last_b, exp_last);
    end

    // Drop counter saturation
    clear_caps();
    repeat (300) send_key(8'h33);
    check("sat_drop_255", drops_a, 255);
    send_key(8'h00);
    check("sat_drop_hold", drops_a, 255);
    repeat (5) tick();
    check("sat_no_tx", cap_a.size(), 0);

    // Overflow: one key is parked in tx_data, four fill the FIFO, sixth drops
    do_reset();
    send_key(8'h11);
    send_key(8'h21);
    send_key(8'h41);
    send_key(8'h81);
    check("ovf_not_full", full_a, 0);
    send_key(8'h12);
    check("ovf_full", full_a, 1);
    check("ovf_no_drop_yet", drops_a, 0);
    send_key(8'h22);
    check("ovf_full_after", full_a, 1);
    check("ovf_drop", drops_a, 1);
    check("ovf_last_key", last_a, 5);
    repeat (10) tick();
    check("ovf_no_tx_stalled", cap_a.size(), 0);
    tx_ready = 1'b1;
    wait_caps(15, 200);
    check("ovf_trig_count", cap_a.size(), 15);
    if (cap_a.size() == 15) begin
      for (int f = 0; f < 5; f++) begin
        check("ovf_digit", cap_a[3*f], ascii_of(f));
        check("ovf_cr", cap_a[3*f+1], 8'h0D);
        check("ovf_lf", cap_a[3*f+2], 8'h0A);
      end
    end
    repeat (10) tick();
    check("ovf_extra_tx", cap_a.size(), 15);
    check("ovf_full_clear", full_a, 0);

    // Holdoff window
    do_reset();
    tx_ready = 1'b1;
    t0 = cyc;
    send_at(8'h12, t0);
    send_at(8'h12, t0 + 50);
    send_at(8'h12, t0 + 160);
    repeat (20) tick();
    check("hold_two_frames", cap_a.size(), 6);
    send_at(8'h22, cyc + 10);
    repeat (20) tick();
    check("hold_diff_code", cap_a.size(), 9);
    a0 = cyc;
    send_at(8'h21, a0);
    send_at(8'h21, a0 + HOLD);
    send_at(8'h21, a0 + HOLD + 1);
    repeat (20) tick();
    check("hold_boundary_count", cap_a.size(), 15);
    exp_lines = '{8'h34, 8'h34, 8'h35, 8'h31, 8'h31};
    if (cap_a.size() == 15) begin
      for (int f = 0; f < 5; f++) check("hold_digit", cap_a[3*f], exp_lines[f]);
    end
    check("hold_no_drop", drops_a, 0);

    // Reset while a CR is waiting and two keys are queued
    do_reset();
    tx_ready = 1'b1;
    send_key(8'h11);
    send_key(8'h21);
    send_key(8'h41);
    wait_caps(2, 40);
    tx_ready = 1'b0;
    repeat (3) tick();
    check("mid_cr_held", data_a, 8'h0D);
    check("mid_two_trig", cap_a.size(), 2);
    reset    = 1'b1;
    tx_ready = 1'b1;
    tick();
    reset     = 1'b0;
    last_trig = -100;
    check("mid_rst_trigger", trig_a, 0);
    check("mid_rst_tx_data", data_a, 8'h00);
    check("mid_rst_full", full_a, 0);
    check("mid_rst_drops", drops_a, 0);
    check("mid_rst_last_key", last_a, 0);
    clear_caps();
    repeat (60) tick();
    check("mid_no_trig_after", cap_a.size(), 0);

    // Randomized traffic against the key-level model
    do_reset();
    exp_q.delete();
    pending    = 0;
    rand_bytes = 0;
    rand_mode  = 1'b1;
    m_drop     = 0;
    m_last     = 0;
    m_acc      = 0;
    m_code     = 8'h00;
    have_acc   = 1'b0;
    for (int k = 0; k < 150; k++) begin
      gap = $urandom_range(1, 130);
      waited = 0;
      while ((waited < gap || pending >= 4) && waited < 5000) begin
        tx_ready = ($urandom_range(0, 9) < 7);
        tick();
        waited++;
      end
      if (waited >= 5000) check("rand_backlog_timeout", pending, 3);
      r = $urandom_range(0, 99);
      if (r < 15) rcode = 8'($urandom);
      else if (r < 50 && have_acc) rcode = m_code;
      else rcode = {4'(1 << $urandom_range(0, 3)), 4'(1 << $urandom_range(0, 3))};
      c = cyc;
      if ($countones(rcode[7:4]) != 1 || $countones(rcode[3:0]) != 1) begin
        if (m_drop < 255) m_drop++;
      end else if (!(have_acc && rcode == m_code && (c - m_acc) <= HOLD)) begin
        have_acc = 1'b1;
        m_code   = rcode;
        m_acc    = c;
        m_last   = 4 * bitpos(rcode[3:0]) + bitpos(rcode[7:4]);
        exp_q.push_back(ascii_of(m_last));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        pending++;
      end
      send_key(rcode);
      check("rand_last_key", last_a, m_last);
      check("rand_drop_count", drops_a, m_drop);
    end
    tx_ready = 1'b1;
    budget = 3000;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("rand_drain", exp_q.size(), 0);
    repeat (10) tick();
    rand_mode = 1'b0;
    check("rand_final_drops", drops_a, m_drop);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
